// File: rtl/unpacked_frame_collector.sv
// Serial-to-frame collector: gathers M handshaked bits into an unpacked frame
// and offers it, with a packed copy, to the downstream stage.
module unpacked_frame_collector #(
    parameter int M    = 2,
    parameter int CNTW = 8
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    input  logic            in_bit,
    output logic            in_ready,
    output logic            frame [0:M-1],
    output logic [0:M-1]    frame_packed,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [CNTW-1:0] frame_count,
    output logic            overflow
);

    localparam int IDXW = $clog2(M);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(M - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            accept;
    logic            handshake;
    logic            dropped;

    assign accept    = (state == FILL) && in_valid;
    assign handshake = (state == HOLD) && frame_ready;
    assign dropped   = (state == HOLD) && in_valid;

    // in_ready and frame_valid are registered copies of the state decode, so
    // neither handshake sees a combinational path from the other side.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= '0;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < M; i++) begin
                frame[i] <= 1'b0;
            end
        end else if (clear) begin
            state       <= FILL;
            idx         <= '0;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < M; i++) begin
                frame[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                frame[idx] <= in_bit;
                if (idx == IDX_LAST) begin
                    idx         <= '0;
                    state       <= HOLD;
                    in_ready    <= 1'b0;
                    frame_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
            if (handshake) begin
                frame_count <= frame_count + 1'b1;
                state       <= FILL;
                in_ready    <= 1'b1;
                frame_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        frame_packed = '0;
        for (int i = 0; i < M; i++) begin
            frame_packed[i] = frame[i];
        end
    end

endmodule

// File: tb/tb_unpacked_frame_collector.sv
// Self-checking bench: an M=4 and an M=2/CNTW=2 collector checked every cycle
// against a bit-count model, plus directed scenarios with literal expectations.
module tb_unpacked_frame_collector;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n0 = 1'b0, clear0 = 1'b0, iv0 = 1'b0, ib0 = 1'b0, fr0 = 1'b0;
    logic       ir0, fv0, ovf0;
    logic       frame0 [0:3];
    logic [0:3] fp0;
    logic [7:0] cnt0;

    logic       rst_n1 = 1'b0, clear1 = 1'b0, iv1 = 1'b0, ib1 = 1'b0, fr1 = 1'b0;
    logic       ir1, fv1, ovf1;
    logic       frame1 [0:1];
    logic [0:1] fp1;
    logic [1:0] cnt1;

    unpacked_frame_collector #(.M(4), .CNTW(8)) dut4 (
        .clock(clock), .rst_n(rst_n0), .clear(clear0),
        .in_valid(iv0), .in_bit(ib0), .in_ready(ir0),
        .frame(frame0), .frame_packed(fp0), .frame_valid(fv0),
        .frame_ready(fr0), .frame_count(cnt0), .overflow(ovf0)
    );

    unpacked_frame_collector #(.M(2), .CNTW(2)) dut2 (
        .clock(clock), .rst_n(rst_n1), .clear(clear1),
        .in_valid(iv1), .in_bit(ib1), .in_ready(ir1),
        .frame(frame1), .frame_packed(fp1), .frame_valid(fv1),
        .frame_ready(fr1), .frame_count(cnt1), .overflow(ovf1)
    );

    int total = 0;
    int bad   = 0;

    // Model: a frame is held exactly when M bits have been collected.
    int mm[2]     = '{4, 2};
    int mmod[2]   = '{256, 4};
    int mlen[2]   = '{0, 0};
    int mcnt[2]   = '{0, 0};
    int movf[2]   = '{0, 0};
    int mframe[2][4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset(input int k);
        mlen[k] = 0;
        mcnt[k] = 0;
        movf[k] = 0;
        for (int i = 0; i < 4; i++) mframe[k][i] = 0;
    endtask

    task automatic modelStep(input int k, input logic iv, input logic ib, input logic fr, input logic clr);
        if (clr) begin
            modelReset(k);
        end else if (mlen[k] == mm[k]) begin
            if (iv) movf[k] = 1;
            if (fr) begin
                mcnt[k] = (mcnt[k] + 1) % mmod[k];
                mlen[k] = 0;
            end
        end else if (iv) begin
            mframe[k][mlen[k]] = int'(ib);
            mlen[k]++;
        end
    endtask

    function automatic int mPacked(input int k);
        int v = 0;
        for (int i = 0; i < mm[k]; i++) v = (v << 1) | mframe[k][i];
        return v;
    endfunction

    always @(posedge clock or negedge rst_n0) begin
        if (!rst_n0) modelReset(0);
        else         modelStep(0, iv0, ib0, fr0, clear0);
    end

    always @(posedge clock or negedge rst_n1) begin
        if (!rst_n1) modelReset(1);
        else         modelStep(1, iv1, ib1, fr1, clear1);
    end

    // Every falling edge, both collectors are compared against the model.
    always @(negedge clock) begin
        checkOutput("in_ready0",     32'(ir0), 32'(mlen[0] != 4));
        checkOutput("frame_valid0",  32'(fv0), 32'(mlen[0] == 4));
        checkOutput("frame0",        32'({frame0[0], frame0[1], frame0[2], frame0[3]}), mPacked(0));
        checkOutput("frame_packed0", 32'(fp0), mPacked(0));
        checkOutput("count0",        32'(cnt0), mcnt[0]);
        checkOutput("overflow0",     32'(ovf0), movf[0]);
        checkOutput("in_ready1",     32'(ir1), 32'(mlen[1] != 2));
        checkOutput("frame_valid1",  32'(fv1), 32'(mlen[1] == 2));
        checkOutput("frame1",        32'({frame1[0], frame1[1]}), mPacked(1));
        checkOutput("frame_packed1", 32'(fp1), mPacked(1));
        checkOutput("count1",        32'(cnt1), mcnt[1]);
        checkOutput("overflow1",     32'(ovf1), movf[1]);
    end

    task automatic applyStimulus(input int k, input logic iv, input logic ib, input logic fr, input logic clr);
        @(negedge clock);
        if (k == 0) begin
            iv0 = iv; ib0 = ib; fr0 = fr; clear0 = clr;
        end else begin
            iv1 = iv; ib1 = ib; fr1 = fr; clear1 = clr;
        end
    endtask

    task automatic sendBits0(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) applyStimulus(0, 1'b1, bits[i], 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int expseq[5] = '{1, 2, 3, 0, 1};

    initial begin
        int k;
        int lastrise;
        logic prevfv;

        repeat (3) @(negedge clock);
        checkOutput("rst_in_ready",    32'(ir0), 32'd1);
        checkOutput("rst_frame_valid", 32'(fv0), 32'd0);
        checkOutput("rst_packed",      32'(fp0), 32'd0);
        checkOutput("rst_count",       32'(cnt0), 32'd0);
        checkOutput("rst_overflow",    32'(ovf0), 32'd0);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;

        sendBits0(4'b1011);
        checkOutput("s1_frame_valid", 32'(fv0), 32'd1);
        checkOutput("s1_packed",      32'(fp0), 32'hb);
        checkOutput("s1_frame",       32'({frame0[0], frame0[1], frame0[2], frame0[3]}), 32'hb);
        checkOutput("s1_in_ready",    32'(ir0), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("s2_hold_stable", 32'(fp0), 32'hb);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_count",       32'(cnt0), 32'd1);
        checkOutput("s2_in_ready",    32'(ir0), 32'd1);
        checkOutput("s2_frame_valid", 32'(fv0), 32'd0);

        sendBits0(4'b1011);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_overflow",     32'(ovf0), 32'd1);
        checkOutput("s3_packed",       32'(fp0), 32'hb);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_overflow_sticky", 32'(ovf0), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s3_clear_overflow", 32'(ovf0), 32'd0);
        checkOutput("s3_clear_packed",   32'(fp0), 32'd0);

        sendBits0(4'b1100);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("s5_count_before", 32'(cnt0), 32'd1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #2 rst_n0 = 1'b0;
        #1;
        checkOutput("s5_async_in_ready",    32'(ir0), 32'd1);
        checkOutput("s5_async_frame_valid", 32'(fv0), 32'd0);
        checkOutput("s5_async_packed",      32'(fp0), 32'd0);
        checkOutput("s5_async_count",       32'(cnt0), 32'd0);
        @(negedge clock);
        rst_n0 = 1'b1;
        sendBits0(4'b0110);
        checkOutput("s5_frame_valid", 32'(fv0), 32'd1);
        checkOutput("s5_packed",      32'(fp0), 32'h6);

        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0);
        sendBits0(4'b1111);
        checkOutput("s6_count_before", 32'(cnt0), 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s6_frame_valid", 32'(fv0), 32'd0);
        checkOutput("s6_in_ready",    32'(ir0), 32'd1);
        checkOutput("s6_packed",      32'(fp0), 32'd0);
        checkOutput("s6_count",       32'(cnt0), 32'd0);

        k = 0;
        lastrise = -1;
        prevfv = 1'b0;
        applyStimulus(1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        for (int n = 1; n <= 15; n++) begin
            applyStimulus(1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (prevfv) begin
                if (k < 5) checkOutput("s4_count_seq", 32'(cnt1), expseq[k]);
                checkOutput("s4_valid_one_cycle", 32'(fv1), 32'd0);
                k++;
            end
            if (fv1 && !prevfv) begin
                if (lastrise >= 0) checkOutput("s4_period", n - lastrise, 32'd3);
                lastrise = n;
            end
            prevfv = fv1;
        end
        checkOutput("s4_handshakes", k, 32'd5);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            iv0    = ($urandom_range(0, 3) != 0);
            ib0    = 1'($urandom_range(0, 1));
            fr0    = 1'($urandom_range(0, 1));
            clear0 = ($urandom_range(0, 63) == 0);
            iv1    = ($urandom_range(0, 3) != 0);
            ib1    = 1'($urandom_range(0, 1));
            fr1    = 1'($urandom_range(0, 1));
            clear1 = ($urandom_range(0, 63) == 0);
        end
        @(negedge clock);
        iv0 = 1'b0; fr0 = 1'b0; clear0 = 1'b0;
        iv1 = 1'b0; fr1 = 1'b0; clear1 = 1'b0;
        repeat (2) @(negedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unpacked_frame_collector.md
# unpacked_frame_collector

Serial-to-frame collector that sits directly upstream of the voting/consumer stage. It accepts one bit per cycle under a valid/ready handshake and assembles M bits into an unpacked array frame indexed [0:M-1]. It presents the frame as both an unpacked and a packed view under a second valid/ready handshake. The downstream stage takes the unpacked frame as its M-entry array input.

## Interface
- M, default 2: frame length in bits; legal range M >= 2.
- CNTW, default 8: width of the completed-frame counter.

- clock  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; highest priority after reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- in_ready  out  1  collector accepts in_bit this cycle.
- frame  out  1 x [0:M-1] unpacked  assembled frame; entry 0 is the first bit received.
- frame_packed  out  [0:M-1]  packed copy of frame, bit-for-bit; index 0 is the MSB.
- frame_valid  out  1  frame holds a complete M-bit frame.
- frame_ready  in  1  consumer takes the frame this cycle.
- frame_count  out  CNTW  number of completed frame handshakes, modulo 2^CNTW.
- overflow  out  1  sticky; set when an input bit was offered and dropped.

## Operation
- There are two states: FILL and HOLD. An index counter idx has width clog2(M) and range 0..M-1.
- FILL:
  - in_ready = 1.
  - On in_valid: frame[idx] <= in_bit, then idx <= idx+1.
  - Accepting the bit at idx == M-1 sets idx <= 0 and moves to HOLD.
- HOLD:
  - in_ready = 0, and frame is held stable.
  - in_valid = 1 in HOLD sets overflow <= 1. The bit is discarded and no frame entry changes.
  - frame_valid & frame_ready completes the handshake: frame_count <= frame_count+1 (wraps to 0), then go to FILL.
- frame_valid == (state == HOLD). It is registered, with no combinational path from frame_ready.
- in_ready == (state == FILL). It is decoded from registered state only, with no path from in_valid or frame_ready.
- Entries not yet rewritten during FILL keep the previous frame's values. frame contents are defined only while frame_valid = 1.
- frame_packed[i] == frame[i] for every i, at all times.
- clear = 1, regardless of state or handshakes:
  - state <= FILL, idx <= 0;
  - every frame entry <= 0;
  - frame_count <= 0, overflow <= 0.
  - No input bit is accepted in that cycle, and no frame handshake counts.
- overflow is cleared only by rst_n or clear.

## Timing
- Reset values with rst_n low (asynchronous):
  - state FILL, idx 0;
  - in_ready 1, frame_valid 0;
  - all frame and frame_packed bits 0;
  - frame_count 0, overflow 0.
- Latency: frame_valid rises on the first edge after the M-th accepted bit.
- A frame handshake in cycle t makes in_ready = 1 in cycle t+1. The minimum frame period is therefore M+1 cycles.
- The frame handshake and an input accept never occur in the same cycle.
- Gaps in in_valid stall idx without losing accepted bits.
- Reset mid-FILL discards the partial frame. The first bit after rst_n deasserts lands in frame[0].
- When clear and frame_ready are both high in HOLD, clear wins and frame_count becomes 0, not +1.

## Test plan
- M=4: drive bits 1,0,1,1 on consecutive cycles with frame_ready=0. Required: frame_valid=1 one cycle after the 4th bit, frame={1,0,1,1}, frame_packed=4'b1011, in_ready=0.
- M=4: after the first scenario, hold frame_ready=0 for 5 cycles, then pulse it. Required: frame stable throughout; frame_count 0 -> 1; in_ready=1 on the next cycle; frame_valid=0.
- M=4: in HOLD, assert in_valid with in_bit=0 for 2 cycles. Required: overflow=1 and stays 1, frame unchanged at {1,0,1,1}; a later clear returns overflow to 0.
- M=2, CNTW=2: complete 5 frames with frame_ready tied high and in_valid always high. Required: frame_count sequence 1,2,3,0,1; each frame_valid lasts one cycle; period 3 cycles.
- M=4: accept 2 bits, assert rst_n=0 asynchronously mid-cycle. Required: outputs go immediately to their reset values. After release, bits 0,1,1,0 give frame={0,1,1,0}.
- M=4: in HOLD, assert clear and frame_ready together. Required: next cycle state FILL, frame all zeros, frame_count=0, frame_valid=0.
